// File: rtl/rf_buffer_burst_master.sv
// Burst initiator for the RF array buffer: turns one (dir, addr, len) command into
// a stream-to-buffer write burst or a buffer-to-stream read burst.
module rf_buffer_burst_master #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 11
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_dir,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic                  done
);

  localparam int CNT_WIDTH = ADDR_WIDTH + 1;
  localparam logic [CNT_WIDTH-1:0] MAX_LEN = CNT_WIDTH'(1) << ADDR_WIDTH;
  localparam int FIFO_DEPTH = 4;

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t                  state_reg, state_next;
  logic [ADDR_WIDTH-1:0]   cur_addr_reg;
  logic [CNT_WIDTH-1:0]    remaining_reg;
  logic                    mem_read_reg, mem_write_reg, rvalid_reg;
  logic [ADDR_WIDTH-1:0]   mem_addr_reg;
  logic [DATA_WIDTH-1:0]   mem_wdata_reg;
  logic [DATA_WIDTH-1:0]   fifo_mem [FIFO_DEPTH];
  logic [1:0]              wr_ptr_reg, rd_ptr_reg;
  logic [2:0]              fifo_count_reg;

  logic                    cmd_fire, s_fire, issue, push, pop;
  logic [CNT_WIDTH-1:0]    len_clamped;
  logic [3:0]              credit;

  always_comb begin
    len_clamped = (32'(cmd_len) > 32'(MAX_LEN)) ? MAX_LEN : CNT_WIDTH'(cmd_len);
  end

  assign cmd_ready = (state_reg == S_IDLE);
  assign busy      = (state_reg != S_IDLE);
  assign done      = (state_reg == S_DONE);
  assign s_ready   = (state_reg == S_WRITE) && (remaining_reg != '0);
  assign m_valid   = (fifo_count_reg != 3'd0);
  assign m_data    = fifo_mem[rd_ptr_reg];
  assign mem_read  = mem_read_reg;
  assign mem_write = mem_write_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;

  assign cmd_fire = cmd_valid && cmd_ready;
  assign s_fire   = s_valid && s_ready;
  assign push     = rvalid_reg;
  assign pop      = m_valid && m_ready;
  // Reads in the memory pipeline hold a FIFO slot; a pop frees one only next cycle.
  assign credit   = 4'(fifo_count_reg) + 4'(mem_read_reg) + 4'(rvalid_reg);
  assign issue    = (state_reg == S_READ) && (remaining_reg != '0) && (credit < 4'(FIFO_DEPTH));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (cmd_fire) begin
          if (len_clamped == '0) state_next = S_DONE;
          else if (cmd_dir)      state_next = S_READ;
          else                   state_next = S_WRITE;
        end
      end
      S_WRITE: if (remaining_reg == '0) state_next = S_DONE;
      // Stay until the last mem_read strobe has actually been driven.
      S_READ:  if ((remaining_reg == '0) && !mem_read_reg) state_next = S_DRAIN;
      S_DRAIN: begin
        if (!mem_read_reg && !rvalid_reg &&
            ((fifo_count_reg == 3'd0) || ((fifo_count_reg == 3'd1) && pop)))
          state_next = S_DONE;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_addr_reg  <= '0;
      remaining_reg <= '0;
      mem_read_reg  <= 1'b0;
      mem_write_reg <= 1'b0;
      rvalid_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
    end else begin
      mem_write_reg <= s_fire;
      mem_read_reg  <= issue;
      rvalid_reg    <= mem_read_reg;
      if (cmd_fire) begin
        cur_addr_reg  <= cmd_addr;
        remaining_reg <= len_clamped;
      end else if (s_fire || issue) begin
        cur_addr_reg  <= cur_addr_reg + 1'b1;
        remaining_reg <= remaining_reg - 1'b1;
        mem_addr_reg  <= cur_addr_reg;
      end
      if (s_fire) mem_wdata_reg <= s_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      fifo_count_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      fifo_count_reg <= fifo_count_reg + 3'(push) - 3'(pop);
    end
  end

  // Entries are cleared on reset so m_data reads 0 while the FIFO is reset.
  generate
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_fifo
      always_ff @(posedge clk or posedge reset) begin
        if (reset)                            fifo_mem[gi] <= '0;
        else if (push && (wr_ptr_reg == gi))  fifo_mem[gi] <= mem_rdata;
      end
    end
  endgenerate

endmodule

// File: tb/tb_rf_buffer_burst_master.sv
// Self-checking bench for rf_buffer_burst_master: buffer model, stream drivers and
// a reference model of expected buffer writes / egress words.
module tb_rf_buffer_burst_master;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int LW = 11;
  localparam int DEPTH = 1 << AW;
  localparam int BOUND = 3000;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0, cmd_ready, cmd_dir = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [LW-1:0] cmd_len = '0;
  logic [DW-1:0] s_data = '0;
  logic          s_valid = 1'b0, s_ready;
  logic [DW-1:0] m_data;
  logic          m_valid, m_ready = 1'b0;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          busy, done;

  always #5 clk = ~clk;

  rf_buffer_burst_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .done(done)
  );

  // Buffer under the master: single port, one-cycle registered read.
  logic [DW-1:0] buf_mem [DEPTH];
  logic [DW-1:0] model_mem [DEPTH];
  always @(posedge clk) begin
    if (mem_write) buf_mem[mem_addr] <= mem_wdata;
    if (mem_read)  mem_rdata <= buf_mem[mem_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] wr_addr_q[$], wr_data_q[$], eg_data_q[$], wq[$];
  int wr_cyc_q[$], s_hs_q[$], eg_cyc_q[$], done_cyc_q[$];
  int rd_cnt = 0, excl_viol = 0, idle_strobe_viol = 0, ready_viol = 0, stall_viol = 0;
  logic stall_pend = 1'b0;
  logic [DW-1:0] stall_data = '0;
  int n_assert = 0, n_fail = 0;
  int hs_cyc = 0, ready_err = 0;

  always @(negedge clk) begin
    if (!reset) begin
      if (mem_write) begin
        wr_addr_q.push_back(DW'(mem_addr));
        wr_data_q.push_back(mem_wdata);
        wr_cyc_q.push_back(cyc);
      end
      if (mem_read) rd_cnt++;
      if (s_valid && s_ready) s_hs_q.push_back(cyc);
      if (m_valid && m_ready) begin
        eg_data_q.push_back(m_data);
        eg_cyc_q.push_back(cyc);
      end
      if (done) done_cyc_q.push_back(cyc);
      if (mem_read && mem_write) excl_viol++;
      if ((mem_read || mem_write) && (!busy || done)) idle_strobe_viol++;
      if (cmd_ready == busy) ready_viol++;
      if (stall_pend && (!m_valid || m_data !== stall_data)) stall_viol++;
      stall_pend = m_valid && !m_ready;
      stall_data = m_data;
    end else begin
      stall_pend = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int clamp_len(input int len);
    return (len > DEPTH) ? DEPTH : len;
  endfunction

  function automatic bit pattern_bit(input bit dir, input int mode, input int k);
    if (mode == 0) return 1'b1;
    if (mode == 1) return dir ? ((k % 4 == 0) || (k % 4 == 3))
                              : ((k % 6 == 0) || (k % 6 == 3) || (k % 6 == 5));
    return ($urandom_range(0, 3) != 0);
  endfunction

  task automatic clear_queues();
    wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete(); s_hs_q.delete();
    eg_data_q.delete(); eg_cyc_q.delete(); done_cyc_q.delete();
    rd_cnt = 0;
  endtask

  task automatic send_cmd(input bit dir, input int addr, input int len);
    int k;
    cmd_dir = dir; cmd_addr = AW'(addr); cmd_len = LW'(len); cmd_valid = 1'b1;
    k = 0;
    forever begin
      @(negedge clk); #1;
      if (cmd_ready) begin hs_cyc = cyc; break; end
      k++;
      if (k > 50) break;
      @(posedge clk); #1;
    end
    check("cmd_handshake", 64'(k <= 50), 64'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic run_burst(input bit dir, input int addr, input int len, input int mode);
    int k, idx, clen;
    bit en;
    clear_queues();
    ready_err = 0;
    clen = clamp_len(len);
    send_cmd(dir, addr, len);
    k = 0; idx = 0;
    while (done_cyc_q.size() == 0 && k < BOUND) begin
      en = pattern_bit(dir, mode, k);
      if (!dir) begin
        s_valid = en && (idx < clen);
        s_data  = (idx < clen) ? wq[idx] : '0;
      end else begin
        m_ready = en;
      end
      @(negedge clk); #1;
      if (busy && !done && !dir && (idx < clen) && !s_ready) ready_err++;
      if (s_ready && (dir || idx >= clen)) ready_err++;
      if (!dir && s_valid && s_ready) idx++;
      @(posedge clk); #1;
      k++;
    end
    s_valid = 1'b0; m_ready = 1'b0;
    check("done_seen", 64'(done_cyc_q.size()), 64'd1);
    check("post_busy_cmd_ready_done", {61'd0, busy, cmd_ready, done}, {61'd0, 1'b0, 1'b1, 1'b0});
    check("s_ready_window", 64'(ready_err), 64'd0);
  endtask

  task automatic verify_write(input string tag, input int addr, input int len);
    int clen, a;
    clen = clamp_len(len);
    check({tag, "_wr_count"}, 64'(wr_addr_q.size()), 64'(clen));
    check({tag, "_rd_count"}, 64'(rd_cnt), 64'd0);
    for (int i = 0; i < clen; i++) begin
      a = (addr + i) % DEPTH;
      model_mem[a] = wq[i];
      if (i < wr_addr_q.size()) begin
        check({tag, "_wr_addr"}, 64'(wr_addr_q[i]), 64'(a));
        check({tag, "_wr_data"}, 64'(wr_data_q[i]), 64'(wq[i]));
        if (i < s_hs_q.size())
          check({tag, "_wr_latency"}, 64'(wr_cyc_q[i] - s_hs_q[i]), 64'd1);
      end
    end
  endtask

  task automatic verify_read(input string tag, input int addr, input int len);
    int clen;
    clen = clamp_len(len);
    check({tag, "_eg_count"}, 64'(eg_data_q.size()), 64'(clen));
    check({tag, "_mem_reads"}, 64'(rd_cnt), 64'(clen));
    check({tag, "_mem_writes"}, 64'(wr_addr_q.size()), 64'd0);
    for (int i = 0; i < clen && i < eg_data_q.size(); i++)
      check({tag, "_eg_data"}, 64'(eg_data_q[i]), 64'(model_mem[(addr + i) % DEPTH]));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctrl"}, {57'd0, cmd_ready, s_ready, m_valid, mem_read, mem_write, busy, done},
          {57'd0, 7'b1000000});
    check({tag, "_m_data"}, 64'(m_data), 64'd0);
    check({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
    check({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
  endtask

  initial begin
    int addr, len, k;
    bit dir;
    logic [DW-1:0] v;
    for (int i = 0; i < DEPTH; i++) begin
      v = $urandom;
      buf_mem[i] = v;
      model_mem[i] = v;
    end
    #1;
    check_reset_outputs("reset");
    #21 reset = 1'b0;
    @(posedge clk); #1;

    // Write wrapping past the top of the buffer
    wq.delete();
    for (int i = 0; i < 4; i++) wq.push_back(DW'(32'hA0 + i));
    run_burst(1'b0, 'h3FE, 4, 0);
    verify_write("wrap", 'h3FE, 4);
    if (wr_cyc_q.size() == 4) check("wrap_back_to_back", 64'(wr_cyc_q[3] - wr_cyc_q[0]), 64'd3);

    // Read it back at full rate
    run_burst(1'b1, 'h3FE, 4, 0);
    verify_read("readback", 'h3FE, 4);
    if (eg_cyc_q.size() == 4) begin
      check("readback_first_latency", 64'(eg_cyc_q[0] - hs_cyc), 64'd4);
      check("readback_full_rate", 64'(eg_cyc_q[3] - eg_cyc_q[0]), 64'd3);
      check("readback_done_after_last", 64'(done_cyc_q[0] > eg_cyc_q[3]), 64'd1);
    end

    // Egress backpressure 1-0-0-1
    run_burst(1'b1, 'h040, 16, 1);
    verify_read("backpressure", 'h040, 16);

    // Ingress gaps 1,0,0,1,0,1
    wq.delete();
    for (int i = 0; i < 3; i++) wq.push_back($urandom);
    run_burst(1'b0, 'h200, 3, 1);
    verify_write("gaps", 'h200, 3);
    if (s_hs_q.size() == 3) begin
      check("gaps_hs0", 64'(s_hs_q[0] - hs_cyc), 64'd1);
      check("gaps_hs1", 64'(s_hs_q[1] - hs_cyc), 64'd4);
      check("gaps_hs2", 64'(s_hs_q[2] - hs_cyc), 64'd6);
    end

    // Zero-length commands, both directions
    for (int d = 0; d < 2; d++) begin
      run_burst(d[0], 'h055, 0, 0);
      check("zero_len_strobes", 64'(wr_addr_q.size() + rd_cnt), 64'd0);
      check("zero_len_done_cycle", 64'(done_cyc_q.size() > 0 ? done_cyc_q[0] - hs_cyc : -1), 64'd1);
    end

    // Over-long read clamps to the whole buffer
    run_burst(1'b1, 'h123, 1500, 0);
    verify_read("clamp", 'h123, 1500);

    // Randomized bursts
    for (int r = 0; r < 8; r++) begin
      dir  = $urandom_range(0, 1);
      addr = $urandom_range(0, DEPTH - 1);
      len  = $urandom_range(1, 24);
      if (!dir) begin
        wq.delete();
        for (int i = 0; i < len; i++) wq.push_back($urandom);
        run_burst(1'b0, addr, len, 2);
        verify_write("rand_wr", addr, len);
      end else begin
        run_burst(1'b1, addr, len, 2);
        verify_read("rand_rd", addr, len);
      end
    end

    // Reset in the middle of a read burst
    clear_queues();
    send_cmd(1'b1, 'h300, 8);
    m_ready = 1'b1;
    k = 0;
    while (eg_data_q.size() < 3 && k < BOUND) begin
      @(negedge clk); #1;
      k++;
    end
    check("midreset_reached", 64'(eg_data_q.size()), 64'd3);
    for (int i = 0; i < 3 && i < eg_data_q.size(); i++)
      check("midreset_eg_data", 64'(eg_data_q[i]), 64'(model_mem[('h300 + i) % DEPTH]));
    reset = 1'b1;
    #1;
    check_reset_outputs("midreset");
    m_ready = 1'b0;
    @(posedge clk); @(posedge clk);
    @(negedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    run_burst(1'b1, 'h3FE, 2, 0);
    verify_read("after_reset", 'h3FE, 2);

    check("never_read_and_write", 64'(excl_viol), 64'd0);
    check("no_strobe_outside_burst", 64'(idle_strobe_viol), 64'd0);
    check("cmd_ready_is_not_busy", 64'(ready_viol), 64'd0);
    check("m_data_stable_under_stall", 64'(stall_viol), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/rf_buffer_burst_master.md
Name: rf_buffer_burst_master

Overview:
- Bus initiator that drives the RF array buffer's single-port read/write interface: mem_read, mem_write, mem_addr, mem_wdata out; mem_rdata in, registered, 1-cycle latency.
- Converts one command (direction, start address, length) into a burst:
  - Write burst: moves words from an ingress valid/ready stream into the buffer.
  - Read burst: moves words from the buffer to an egress valid/ready stream.
- Sits between the buffer and the DSP/DMA stream fabric, so streaming does not need per-word RISC-V accesses.

Parameters:
- ADDR_WIDTH, 10, buffer address width; must match the buffer.
- DATA_WIDTH, 32, word width.
- LEN_WIDTH, 11, burst length field width; max burst 2^ADDR_WIDTH words.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when both high; high only in IDLE
- cmd_dir  in  1  0 = stream-to-buffer (write), 1 = buffer-to-stream (read)
- cmd_addr  in  ADDR_WIDTH  start word address
- cmd_len  in  LEN_WIDTH  burst length in words; 0 = no-op
- s_data  in  DATA_WIDTH  ingress word
- s_valid  in  1  ingress valid
- s_ready  out  1  ingress ready
- m_data  out  DATA_WIDTH  egress word
- m_valid  out  1  egress valid
- m_ready  in  1  egress ready
- mem_read  out  1  buffer read strobe (registered)
- mem_write  out  1  buffer write strobe (registered)
- mem_addr  out  ADDR_WIDTH  buffer address (registered)
- mem_wdata  out  DATA_WIDTH  buffer write data (registered)
- mem_rdata  in  DATA_WIDTH  buffer read data; valid the cycle after mem_read is high
- busy  out  1  high whenever state is not IDLE
- done  out  1  one-cycle pulse at burst completion

Behaviour:
- Reset: asynchronous. State = IDLE; counters cleared; egress FIFO emptied. All outputs 0 except cmd_ready = 1.
- Reset mid-burst: aborts immediately with no further mem strobes. Buffer contents already written remain.
- States and transitions:
  - IDLE -> WRITE / READ / DONE on cmd handshake. Latch addr, len, dir; len = 0 goes to DONE.
  - WRITE -> DONE after the cycle in which the last mem_write is driven.
  - READ -> DRAIN once len reads have been issued.
  - DRAIN -> DONE when no read is in flight, the FIFO is empty and the last word has handshaken on m_*.
  - DONE: done = 1 for one cycle, then IDLE.
- WRITE:
  - s_ready = 1 while words remain to be accepted; otherwise 0.
  - Handshake in cycle t gives mem_write = 1, mem_addr = cur_addr, mem_wdata = s_data in cycle t+1.
  - cur_addr then increments. Sustains 1 word/cycle; s_valid gaps produce mem_write = 0 cycles.
- READ:
  - Read is issued when words remain and fifo_count + inflight < 4. Pop is not credited in the same cycle.
  - Issue decided in cycle t gives mem_read = 1 with mem_addr in t+1. mem_rdata is pushed into a 4-entry egress FIFO at the end of t+2.
  - m_valid = FIFO non-empty; m_data = FIFO head (registered output); pop on m_valid && m_ready.
  - Sustains 1 word/cycle with m_ready held high. First m_valid comes 4 cycles after the cmd handshake cycle.
- Address arithmetic:
  - cur_addr wraps modulo 2^ADDR_WIDTH.
  - cmd_len > 2^ADDR_WIDTH is clamped to 2^ADDR_WIDTH.
- Exclusivity and ignored inputs:
  - mem_read and mem_write are never high in the same cycle; both are 0 outside WRITE/READ.
  - mem_addr and mem_wdata hold their last value when strobes are low.
  - s_ready = 0 outside WRITE; s_valid is ignored there.
  - cmd_valid is ignored while busy.
- No word is dropped or duplicated under any m_ready/s_valid pattern. Egress order equals address order.

Test Plan:
- Write wrap: cmd dir = 0, addr = 0x3FE, len = 4; s_data 0xA0..0xA3 back-to-back -> mem_write on 4 consecutive cycles at addr 0x3FE, 0x3FF, 0x000, 0x001; done pulses once; busy then falls.
- Read-back full rate: after the write, cmd dir = 1, addr = 0x3FE, len = 4, m_ready = 1 -> m_data 0xA0, 0xA1, 0xA2, 0xA3 on consecutive cycles; first m_valid 4 cycles after the cmd handshake; then done.
- Backpressure: read len = 16 with m_ready toggling 1-0-0-1 -> all 16 words in order, none lost or duplicated; fifo_count + inflight never exceeds 4; m_data stable while m_valid && !m_ready.
- Ingress gaps: write len = 3 with s_valid pattern 1,0,0,1,0,1 -> exactly 3 mem_write cycles, each one cycle after its handshake; s_ready drops after the 3rd word.
- Zero length: cmd len = 0 -> no mem_read/mem_write; done 1 cycle after the handshake; cmd_ready high the following cycle.
- Reset mid-read: assert reset during the 3rd word of a len = 8 read -> all outputs 0 immediately, cmd_ready = 1; a fresh read len = 2 afterwards returns correct data.
